// File: rtl/pipe_reg_chain.sv
// ---------------------------------------------------------------------------
// pipe_reg_chain
//
// Parametrised chain of pipeline boundary registers with a built-in stall
// controller. Register k sits between stage k and stage k+1 and carries a
// DATA_W payload plus a valid bit.
//
// The per-stage stall requests are folded into a monotonic stall vector: the
// highest requesting stage stalls itself and every stage upstream of it.
// A register whose upstream side is stalled but whose downstream side is free
// takes a bubble, so the downstream part of the pipe keeps draining while the
// upstream part holds.
//
// Ports
//   clk            core clock, rising edge
//   rst            asynchronous active-high reset
//   stall_req_i    [STAGES:0]          stage j cannot complete this cycle
//   flush_i        synchronous clear of every boundary register
//   stage_data_i   [STAGES*DATA_W-1:0] slice k = output of stage k
//   stage_valid_i  [STAGES-1:0]        valid bit for slice k
//   reg_data_o     [STAGES*DATA_W-1:0] slice k = contents of register k
//   reg_valid_o    [STAGES-1:0]        valid bit of register k
//   stall_o        [STAGES:0]          monotonic stall vector (combinational)
//   stall_cnt_o    [CNT_W-1:0]         saturating count of cycles with stall_o[0]
// ---------------------------------------------------------------------------
module pipe_reg_chain #(
  parameter int DATA_W = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STAGES:0]          stall_req_i,
  input  logic                     flush_i,
  input  logic [STAGES*DATA_W-1:0] stage_data_i,
  input  logic [STAGES-1:0]        stage_valid_i,
  output logic [STAGES*DATA_W-1:0] reg_data_o,
  output logic [STAGES-1:0]        reg_valid_o,
  output logic [STAGES:0]          stall_o,
  output logic [CNT_W-1:0]         stall_cnt_o
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  // Per-register update selection
  typedef enum logic [1:0] {
    UPD_HOLD    = 2'd0,
    UPD_CAPTURE = 2'd1,
    UPD_BUBBLE  = 2'd2,
    UPD_CLEAR   = 2'd3
  } upd_e;

  logic [STAGES:0]  stall_s;
  upd_e             upd_s   [STAGES];
  logic [DATA_W-1:0] data_r [STAGES];
  logic             valid_r [STAGES];
  logic [CNT_W-1:0] cnt_r;
  logic             cnt_inc_s;

  // Stall vector: OR-scan from the last stage downwards, so every stage at or
  // below the highest requester is stalled.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    stall_s = '0;
    for (int j = STAGES; j >= 0; j--) begin
      acc        = acc | stall_req_i[j];
      stall_s[j] = acc;
    end
  end

  assign stall_o = stall_s;

  // Choose the update rule for each boundary register; flush dominates,
  // then the stall edge (stalled upstream, free downstream) takes a bubble.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      upd_s[k] = UPD_HOLD;
      if (flush_i) begin
        upd_s[k] = UPD_CLEAR;
      end else if (stall_s[k] && !stall_s[k+1]) begin
        upd_s[k] = UPD_BUBBLE;
      end else if (!stall_s[k]) begin
        upd_s[k] = UPD_CAPTURE;
      end else begin
        upd_s[k] = UPD_HOLD;
      end
    end
  end

  // Boundary registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        data_r[k]  <= DATA_ZERO;
        valid_r[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        case (upd_s[k])
          UPD_CLEAR, UPD_BUBBLE: begin
            data_r[k]  <= DATA_ZERO;
            valid_r[k] <= 1'b0;
          end
          UPD_CAPTURE: begin
            // Invalid slots are registered as-is; consumers qualify on valid.
            data_r[k]  <= stage_data_i[k*DATA_W +: DATA_W];
            valid_r[k] <= stage_valid_i[k];
          end
          UPD_HOLD: begin
            data_r[k]  <= data_r[k];
            valid_r[k] <= valid_r[k];
          end
          default: begin
            data_r[k]  <= DATA_ZERO;
            valid_r[k] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Counter advances on a front-of-pipe stall unless the cycle is a flush,
  // and sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_inc_s = 1'b0;
    if (stall_s[0] && !flush_i && (cnt_r != CNT_MAX)) begin
      cnt_inc_s = 1'b1;
    end else begin
      cnt_inc_s = 1'b0;
    end
  end

  // Stall-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign stall_cnt_o = cnt_r;

  // Flatten the register array onto the output buses.
  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_out
      assign reg_data_o[g*DATA_W +: DATA_W] = data_r[g];
      assign reg_valid_o[g]                 = valid_r[g];
    end
  endgenerate

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Testbench for pipe_reg_chain: a behavioural model (highest requesting stage
// decides hold / bubble / capture per register) is compared against the DUT on
// every falling edge. A second instance with a 4-bit counter covers saturation.
module tb_pipe_reg_chain;
  localparam int DATA_W = 32;
  localparam int STAGES = 4;

  logic                     clk;
  logic                     rst;
  logic [STAGES:0]          stall_req_i;
  logic                     flush_i;
  logic [STAGES*DATA_W-1:0] stage_data_i;
  logic [STAGES-1:0]        stage_valid_i;
  logic [STAGES*DATA_W-1:0] reg_data_o, reg_data_b;
  logic [STAGES-1:0]        reg_valid_o, reg_valid_b;
  logic [STAGES:0]          stall_o, stall_b;
  logic [15:0]              stall_cnt_o;
  logic [3:0]               stall_cnt_b;

  int n_cmp;
  int n_fail;

  pipe_reg_chain #(.DATA_W(DATA_W), .STAGES(STAGES), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall_req_i(stall_req_i), .flush_i(flush_i),
    .stage_data_i(stage_data_i), .stage_valid_i(stage_valid_i),
    .reg_data_o(reg_data_o), .reg_valid_o(reg_valid_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  pipe_reg_chain #(.DATA_W(DATA_W), .STAGES(STAGES), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stall_req_i(stall_req_i), .flush_i(flush_i),
    .stage_data_i(stage_data_i), .stage_valid_i(stage_valid_i),
    .reg_data_o(reg_data_b), .reg_valid_o(reg_valid_b),
    .stall_o(stall_b), .stall_cnt_o(stall_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_data  [STAGES];
  logic              m_valid [STAGES];
  int                m_cnt;

  function automatic int top_req(input logic [STAGES:0] req);
    int m;
    m = -1;
    for (int j = 0; j <= STAGES; j++) if (req[j]) m = j;
    return m;
  endfunction

  function automatic logic [STAGES:0] exp_stall(input logic [STAGES:0] req);
    int m;
    m = top_req(req);
    if (m < 0) return '0;
    return (STAGES+1)'((64'd1 << (m + 1)) - 64'd1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        m_data[k]  <= '0;
        m_valid[k] <= 1'b0;
      end
      m_cnt <= 0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush_i) begin
          m_data[k]  <= '0;
          m_valid[k] <= 1'b0;
        end else if (top_req(stall_req_i) < k) begin
          m_data[k]  <= stage_data_i[k*DATA_W +: DATA_W];
          m_valid[k] <= stage_valid_i[k];
        end else if (top_req(stall_req_i) == k) begin
          m_data[k]  <= '0;
          m_valid[k] <= 1'b0;
        end
      end
      if (!flush_i && top_req(stall_req_i) >= 0) m_cnt <= m_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      check($sformatf("data[%0d]", k), 64'(reg_data_o[k*DATA_W +: DATA_W]), 64'(m_data[k]));
      check($sformatf("valid[%0d]", k), 64'(reg_valid_o[k]), 64'(m_valid[k]));
      check($sformatf("sat_data[%0d]", k), 64'(reg_data_b[k*DATA_W +: DATA_W]), 64'(m_data[k]));
    end
    check("stall_o", 64'(stall_o), 64'(exp_stall(stall_req_i)));
    check("stall_cnt", 64'(stall_cnt_o), 64'((m_cnt > 65535) ? 65535 : m_cnt));
    check("sat_cnt", 64'(stall_cnt_b), 64'((m_cnt > 15) ? 15 : m_cnt));
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [STAGES:0] req, input logic fl, input int base,
                       input logic [STAGES-1:0] vld);
    #1;
    stall_req_i   = req;
    flush_i       = fl;
    stage_valid_i = vld;
    for (int k = 0; k < STAGES; k++) stage_data_i[k*DATA_W +: DATA_W] = DATA_W'(base + k);
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    #1 rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    stall_req_i = '0;
    flush_i = 1'b0;
    stage_data_i = '0;
    stage_valid_i = '0;
    tick();
    check("reset_valid", 64'(reg_valid_o), 64'h0);
    check("reset_cnt", 64'(stall_cnt_o), 64'h0);
    #1 rst = 1'b0;

    // Free flow
    drive(5'b00000, 1'b0, 32'h100, 4'b1111);
    tick();
    for (int k = 0; k < STAGES; k++)
      check("free_data", 64'(reg_data_o[k*DATA_W +: DATA_W]), 64'(32'h100 + k));
    check("free_valid", 64'(reg_valid_o), 64'hF);
    check("free_stall", 64'(stall_o), 64'h0);
    check("free_cnt", 64'(stall_cnt_o), 64'h0);

    // Mid stall with new data offered upstream
    drive(5'b00100, 1'b0, 32'h200, 4'b1111);
    repeat (3) tick();
    check("mid_stall_o", 64'(stall_o), 64'h07);
    check("mid_reg0", 64'(reg_data_o[0 +: DATA_W]), 64'h100);
    check("mid_reg1", 64'(reg_data_o[DATA_W +: DATA_W]), 64'h101);
    check("mid_reg2", 64'(reg_data_o[2*DATA_W +: DATA_W]), 64'h0);
    check("mid_reg3", 64'(reg_data_o[3*DATA_W +: DATA_W]), 64'h203);
    check("mid_valid", 64'(reg_valid_o), 64'hB);
    check("mid_cnt", 64'(stall_cnt_o), 64'd3);

    // Release
    drive(5'b00000, 1'b0, 32'h300, 4'b1111);
    tick();
    check("rel_reg0", 64'(reg_data_o[0 +: DATA_W]), 64'h300);
    check("rel_reg1", 64'(reg_data_o[DATA_W +: DATA_W]), 64'h301);

    // Priority: highest request wins
    drive(5'b01010, 1'b0, 32'h400, 4'b1111);
    tick();
    check("prio_stall_o", 64'(stall_o), 64'h0F);
    check("prio_valid", 64'(reg_valid_o), 64'h7);
    check("prio_reg2", 64'(reg_data_o[2*DATA_W +: DATA_W]), 64'h302);
    check("prio_cnt", 64'(stall_cnt_o), 64'd4);

    // Flush during stall
    drive(5'b00010, 1'b1, 32'h500, 4'b1111);
    tick();
    check("flush_valid", 64'(reg_valid_o), 64'h0);
    check("flush_data", 64'(reg_data_o), 64'h0);
    check("flush_stall_o", 64'(stall_o), 64'h03);
    check("flush_cnt", 64'(stall_cnt_o), 64'd4);

    // Last-stage stall: everything holds
    drive(5'b00000, 1'b0, 32'h600, 4'b1111);
    tick();
    drive(5'b10000, 1'b0, 32'h700, 4'b0000);
    tick();
    check("last_valid", 64'(reg_valid_o), 64'hF);
    check("last_reg3", 64'(reg_data_o[3*DATA_W +: DATA_W]), 64'h603);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      logic [STAGES:0] req;
      req = ($urandom_range(0, 2) == 0) ? (STAGES+1)'($urandom) : '0;
      drive(req, ($urandom_range(0, 15) == 0), int'($urandom), STAGES'($urandom));
      tick();
    end

    // Saturation
    do_reset();
    drive(5'b00001, 1'b0, 32'h800, 4'b1111);
    repeat (15) tick();
    check("sat15", 64'(stall_cnt_b), 64'd15);
    repeat (5) tick();
    check("sat_hold", 64'(stall_cnt_b), 64'd15);
    check("sat_wide", 64'(stall_cnt_o), 64'd20);

    // Async reset mid-stall
    drive(5'b00000, 1'b0, 32'h900, 4'b1111);
    tick();
    drive(5'b11111, 1'b0, 32'hA00, 4'b1111);
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(reg_valid_o), 64'h0);
    check("arst_data", 64'(reg_data_o), 64'h0);
    check("arst_cnt", 64'(stall_cnt_o), 64'h0);
    check("arst_sat_cnt", 64'(stall_cnt_b), 64'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    drive(5'b00000, 1'b0, 32'hB00, 4'b1111);
    tick();
    check("post_rst_reg0", 64'(reg_data_o[0 +: DATA_W]), 64'hB00);
    check("post_rst_valid", 64'(reg_valid_o), 64'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised pipeline register chain that replaces the fixed per-boundary stage registers (fetch/decode, decode/execute, execute/memory, memory/writeback) with one block.
- STAGES boundary registers carry a DATA_W payload plus a valid bit.
- Includes a built-in stall controller: per-stage stall requests are turned into a monotonic stall vector, with bubble insertion, global flush, and a saturating stall-cycle counter.
- Sits between the combinational stage logic blocks inside the core top level.

Parameters:
- DATA_W, 32, payload bits per boundary register
- STAGES, 4, number of boundary registers; stages are numbered 0..STAGES, and register k sits between stage k and stage k+1
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-high reset
- stall_req_i  input  STAGES+1  stall_req_i[j]=1: stage j cannot complete this cycle
- flush_i  input  1  synchronous flush of all boundary registers
- stage_data_i  input  STAGES*DATA_W  slice k = output of stage k, destined for register k
- stage_valid_i  input  STAGES  valid bit accompanying slice k
- reg_data_o  output  STAGES*DATA_W  slice k = contents of register k (input to stage k+1)
- reg_valid_o  output  STAGES  valid bit of register k
- stall_o  output  STAGES+1  internal stall vector, exported for pc hold and regfile write gating
- stall_cnt_o  output  CNT_W  number of cycles in which stall_o[0]=1, saturating

Behaviour:
- Reset (asynchronous, rst=1): all reg_data_o slices = 0, reg_valid_o = 0, stall_cnt_o = 0. Reset is effective immediately, including mid-stall or mid-flush.
- stall_o is combinational from stall_req_i:
  - Let m = highest index j with stall_req_i[j]=1.
  - stall_o[j]=1 for all j<=m, and 0 for all j>m.
  - No request: stall_o = 0.
  - Multiple simultaneous requests resolve to the highest index.
- Register k update on the rising clk edge, first matching rule wins:
  1. flush_i=1: data=0, valid=0. Flush overrides every stall.
  2. stall_o[k]=1 and stall_o[k+1]=0: insert a bubble (data=0, valid=0). Downstream drains while upstream holds.
  3. stall_o[k]=0: capture stage_data_i slice k and stage_valid_i[k].
  4. Otherwise (both stalled): hold the current value.
- Latency: 1 cycle from stage_data_i slice k to reg_data_o slice k when unstalled.
  - With no stalls or flushes, a token injected at stage 0 appears at reg k after k+1 cycles, provided each stage passes it through combinationally.
- stall_cnt_o: increments by 1 on each edge where stall_o[0]=1 and flush_i=0. It holds at all-ones (saturation) and never wraps.
- Stall at the last stage (stall_req_i[STAGES]=1): all registers hold and no bubble is inserted anywhere. stall_o[STAGES] is exported so the writeback consumer suppresses its write.
- flush_i and stall_req_i in the same cycle: registers are cleared per rule 1, stall_o is still driven from the requests, and the counter does not increment.
- Stall released: normal capture resumes on the next edge; held contents are not lost or duplicated.
- Data of an invalid slot is still registered as-is (rule 3); consumers qualify on valid.
- Widths: slice k occupies bits [k*DATA_W +: DATA_W]. The stall vector has STAGES+1 bits, so stall_o[k+1] always exists for every register k.

Test Plan:
(Defaults DATA_W=32, STAGES=4, CNT_W=16 unless noted.)
- Free flow: release rst, then drive slice k = 0x100+k with all valid each cycle and no stall_req.
  -> After one edge, reg_data_o slices = 0x100..0x103, reg_valid_o = 4'b1111, stall_o = 0, stall_cnt_o = 0.
- Mid stall: stall_req_i = 5'b00100 for 3 cycles.
  -> stall_o = 5'b00111; regs 0,1 hold their values; reg 2 becomes 0 with valid=0 on every stalled edge; reg 3 captures normally; stall_cnt_o = 3.
  -> On release, reg 0 and reg 1 resume capturing.
- Priority: stall_req_i = 5'b01010.
  -> stall_o = 5'b01111; regs 0-2 hold; reg 3 takes a bubble.
- Flush during stall: stall_req_i = 5'b00010 together with flush_i=1 for 1 cycle.
  -> All reg_valid_o = 0 and all data = 0 after the edge; stall_cnt_o unchanged.
- Saturation: CNT_W=4, stall_req_i[0]=1 held for 20 cycles.
  -> stall_cnt_o reaches 15 after 15 cycles and stays at 15.
- Async reset mid-stall: assert rst between edges while stall_req_i = 5'b11111.
  -> Outputs clear immediately, before the next edge; after rst deasserts with no requests, the chain captures on the first edge.
